rr_arb_mux_4: RTL

RR_ARB_MUX_4 -- requirements
Module: rr_arb_mux_4

---
 rtl/rr_arb_mux_4.sv | 110 +++++++++++
 1 files changed

// File: rtl/rr_arb_mux_4.sv
// rtl/rr_arb_mux_4.sv - 4-way round-robin arbiter with a registered output beat.
// Define ARB_LOCK_EN to add the lock port and the burst lock-holder register.
module rr_arb_mux_4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_data,
  output logic [3:0]         req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         sel
`ifdef ARB_LOCK_EN
  ,
  input  logic [3:0]         lock
`endif
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [1:0]       ptr;
  logic             slot_free;
  logic             cand_vld;
  logic [1:0]       cand_idx;
  logic [1:0]       scan_idx;
  logic             grant;
  logic [WIDTH-1:0] cand_data;

`ifdef ARB_LOCK_EN
  logic             hold_vld;
  logic [1:0]       hold_idx;
`endif

  assign slot_free = (state == IDLE) | out_ready;
  assign out_valid = (state == BUSY);

  // Scan starts just after the last winner, so the first hit is the round-robin choice.
  always_comb begin
    cand_vld = 1'b0;
    cand_idx = ptr;
    scan_idx = ptr;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = ptr + 2'(k);
      if (!cand_vld && req_valid[scan_idx]) begin
        cand_vld = 1'b1;
        cand_idx = scan_idx;
      end
    end
`ifdef ARB_LOCK_EN
    if (hold_vld) begin
      cand_vld = req_valid[hold_idx];
      cand_idx = hold_idx;
    end
`endif
  end

  assign grant = rst_n & slot_free & cand_vld;

  always_comb begin
    req_ready = 4'b0000;
    if (grant) req_ready = 4'b0001 << cand_idx;
  end

  always_comb begin
    cand_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (cand_idx == 2'(i)) cand_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    if (grant)                            state_nxt = BUSY;
    else if (state == BUSY && out_ready)  state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ptr resets to 3 so requester 0 wins the first scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      sel      <= 2'd0;
      ptr      <= 2'd3;
    end else if (grant) begin
      out_data <= cand_data;
      sel      <= cand_idx;
      ptr      <= cand_idx;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld <= 1'b0;
      hold_idx <= 2'd0;
    end else if (grant) begin
      hold_vld <= lock[cand_idx];
      hold_idx <= cand_idx;
    end
  end
`endif

endmodule
